// File: rtl/pixel_framebuffer.sv
// pixel_framebuffer
//   Paint-canvas framebuffer sitting between the brush/input logic and the VGA colour path.
//   Holds a GRID x GRID array of COLOR_W-bit colour codes in one simple dual-port RAM.
//   The write side stamps square brushes (radius 0..3) or clears the whole canvas, one RAM
//   write per cycle, under a ready/valid handshake. The read side is a free-running,
//   one-cycle-latency VGA lookup that returns BORDER_COLOR outside the canvas.
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous, active-low reset
//   wr_valid     in   brush stamp request
//   wr_ready     out  idle, a stamp or clear can be accepted
//   wx, wy       in   stamp centre (canvas coordinates)
//   brush_radius in   r; the stamp covers a (2r+1)x(2r+1) square
//   new_color    in   stamp colour
//   clear_req    in   clear the whole canvas; wins over wr_valid
//   op_done      out  one-cycle pulse after a stamp/clear finishes
//   rx, ry       in   VGA scan position
//   color_code   out  colour at (rx, ry), valid one cycle later
module pixel_framebuffer #(
  parameter int                 COORD_W      = 7,
  parameter int                 COLOR_W      = 3,
  parameter int                 SCAN_W       = 10,
  parameter logic [COLOR_W-1:0] BORDER_COLOR = COLOR_W'(1),
  parameter logic [COLOR_W-1:0] CLEAR_COLOR  = COLOR_W'(0)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [COORD_W-1:0] wx,
  input  logic [COORD_W-1:0] wy,
  input  logic [1:0]         brush_radius,
  input  logic [COLOR_W-1:0] new_color,
  input  logic               clear_req,
  output logic               op_done,
  input  logic [SCAN_W-1:0]  rx,
  input  logic [SCAN_W-1:0]  ry,
  output logic [COLOR_W-1:0] color_code
);

  localparam int GRID   = 2 ** COORD_W;
  localparam int ADDR_W = 2 * COORD_W;
  localparam int OFF_W  = COORD_W + 2;

  typedef enum logic [1:0] {IDLE, PAINT, CLEAR} state_e;

  state_e              state_q;
  logic                wr_ready_q;
  logic                op_done_q;
  logic [COORD_W-1:0]  cx_q, cy_q;
  logic [1:0]          r_q;
  logic [COLOR_W-1:0]  col_q;
  logic signed [2:0]   dx_q, dy_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic [COLOR_W-1:0]  color_q;

  logic [COLOR_W-1:0]  mem [GRID*GRID];

  logic signed [2:0]   r_s, r_in_s;
  logic [OFF_W-1:0]    tx, ty;
  logic                x_ok, y_ok;
  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [COLOR_W-1:0]  wdata;
  logic                in_canvas;
  logic [ADDR_W-1:0]   raddr;

  assign r_s    = $signed({1'b0, r_q});
  assign r_in_s = $signed({1'b0, brush_radius});

  // Stamp target: unsigned centre plus sign-extended offset. The sum lies in -3..GRID+2, so
  // it is on the canvas exactly when the two extra top bits are zero (negatives wrap to 11).
  assign tx   = {2'b00, cx_q} + {{(OFF_W-3){dx_q[2]}}, dx_q};
  assign ty   = {2'b00, cy_q} + {{(OFF_W-3){dy_q[2]}}, dy_q};
  assign x_ok = (tx[OFF_W-1:COORD_W] == 2'b00);
  assign y_ok = (ty[OFF_W-1:COORD_W] == 2'b00);

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    case (state_q)
      PAINT: begin
        we    = x_ok && y_ok;
        waddr = {ty[COORD_W-1:0], tx[COORD_W-1:0]};
        wdata = col_q;
      end
      CLEAR: begin
        we    = 1'b1;
        waddr = ptr_q;
        wdata = CLEAR_COLOR;
      end
      default: ;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wr_ready_q <= 1'b1;
      op_done_q  <= 1'b0;
      cx_q       <= '0;
      cy_q       <= '0;
      r_q        <= '0;
      col_q      <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      ptr_q      <= '0;
    end else begin
      op_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (clear_req) begin
            state_q    <= CLEAR;
            wr_ready_q <= 1'b0;
            ptr_q      <= '0;
          end else if (wr_valid) begin
            state_q    <= PAINT;
            wr_ready_q <= 1'b0;
            cx_q       <= wx;
            cy_q       <= wy;
            r_q        <= brush_radius;
            col_q      <= new_color;
            dx_q       <= -r_in_s;
            dy_q       <= -r_in_s;
          end
        end
        PAINT: begin
          // Clipped offsets still consume their cycle, so stamp length depends only on r.
          if (dx_q == r_s) begin
            dx_q <= -r_s;
            if (dy_q == r_s) begin
              state_q    <= IDLE;
              wr_ready_q <= 1'b1;
              op_done_q  <= 1'b1;
            end else begin
              dy_q <= dy_q + 3'sd1;
            end
          end else begin
            dx_q <= dx_q + 3'sd1;
          end
        end
        CLEAR: begin
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == '1) begin
            state_q    <= IDLE;
            wr_ready_q <= 1'b1;
            op_done_q  <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          wr_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // NOTE: the canvas RAM has no reset, so it maps onto block RAM and survives a reset untouched.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: the RAM read and the in-canvas decision share one output register, so a
  // same-address write in the same cycle is seen only on the following read.
  assign in_canvas = (rx < SCAN_W'(GRID)) && (ry < SCAN_W'(GRID));
  assign raddr     = {ry[COORD_W-1:0], rx[COORD_W-1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) color_q <= '0;
    else        color_q <= in_canvas ? mem[raddr] : BORDER_COLOR;
  end

  assign wr_ready   = wr_ready_q;
  assign op_done    = op_done_q;
  assign color_code = color_q;

endmodule
